// File: rtl/dreimann_seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per enabled clock,
// start/done handshake, result registers that change only on entry to DONE.
module dreimann_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] dsr;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // quo_w starts as the dividend and is shifted out MSB-first while quotient
  // bits enter at the LSB, so after WIDTH steps it holds the quotient.
  always_comb begin
    shifted  = {rem_w, quo_w[WIDTH-1]};
    trial    = shifted - {1'b0, dsr};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo_w[WIDTH-2:0], q_bit};
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_w       <= '0;
      quo_w       <= '0;
      dsr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            quo_w <= dividend;
            dsr   <= divisor;
            rem_w <= '0;
            if (divisor != '0) begin
              state <= CALC;
              cnt   <= CNT_W'(WIDTH - 1);
            end else begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem_w <= rem_next;
          quo_w <= quo_next;
          if (cnt == '0) begin
            state       <= DONE;
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dreimann_seq_divider.sv
// Self-checking bench for dreimann_seq_divider: directed scenarios plus a
// randomized sweep compared against plain integer division.
module tb_dreimann_seq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dreimann_seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Reference: integer division, all-ones quotient for a zero divisor.
  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one operation and return edges after the capture edge until done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bcyc);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    bcyc  = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    total_cnt++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0)
      $display("FAIL reset_outputs: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset_idle: got busy=%0b done=%0b, want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat, bc;
    do_op(8'd200, 8'd7, lat, bc);
    total_cnt++;
    if (lat !== 8) $display("FAIL basic_latency: got %0d, want 8", lat); else pass_cnt++;
    total_cnt++;
    if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d, want 8", bc); else pass_cnt++;
    total_cnt++;
    if ({div_by_zero, quotient, remainder} !== {1'b0, 8'd28, 8'd4})
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%0b, want q=28 r=4 dbz=0",
               quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: done=%0b one cycle later, want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_boundary;
    logic [W-1:0] ta [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [W-1:0] tb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
    int lat, bc, eq, er;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], lat, bc);
      ref_div(int'(ta[i]), int'(tb[i]), eq, er);
      total_cnt++;
      if ({quotient, remainder} !== {W'(eq), W'(er)})
        $display("FAIL boundary_%0d/%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                 ta[i], tb[i], quotient, remainder, eq, er);
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_by_zero;
    int lat, bc;
    do_op(8'd77, 8'd0, lat, bc);
    total_cnt++;
    if (lat !== 0 || bc !== 0)
      $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d, want 0 0", lat, bc);
    else pass_cnt++;
    total_cnt++;
    if ({div_by_zero, quotient, remainder} !== {1'b1, 8'd255, 8'd77})
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%0b, want q=255 r=77 dbz=1",
               quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(posedge clk); #1;
    do_op(8'd10, 8'd3, lat, bc);
    total_cnt++;
    if ({div_by_zero, quotient, remainder} !== {1'b0, 8'd3, 8'd1})
      $display("FAIL dbz_followup: got q=%0d r=%0d dbz=%0b, want q=3 r=1 dbz=0",
               quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_hold_start;
    int n_done = 0;
    int edge_at = -1;
    dividend = 8'd100; divisor = 8'd10; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 24; i++) begin
      if (i == 3) begin dividend = 8'd33; divisor = 8'd5; end
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin edge_at = i; start = 1'b0; end
      end
    end
    start = 1'b0;
    total_cnt++;
    if (n_done !== 1 || edge_at !== 8)
      $display("FAIL hold_start_pulses: got %0d pulses first at edge %0d, want 1 at 8", n_done, edge_at);
    else pass_cnt++;
    total_cnt++;
    if ({quotient, remainder} !== {8'd10, 8'd0})
      $display("FAIL hold_start_result: got q=%0d r=%0d, want q=10 r=0", quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    do_op(8'd60, 8'd7, lat, bc);
    dividend = 8'd9; divisor = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%0b after DONE edge, want 1", busy);
    else pass_cnt++;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    total_cnt++;
    if ({quotient, remainder} !== {8'd8, 8'd4})
      $display("FAIL b2b_hold_outputs: got q=%0d r=%0d mid-CALC, want q=8 r=4", quotient, remainder);
    else pass_cnt++;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    total_cnt++;
    if (lat !== 8) $display("FAIL b2b_latency: got %0d, want 8", lat); else pass_cnt++;
    total_cnt++;
    if ({quotient, remainder} !== {8'd4, 8'd1})
      $display("FAIL b2b_result: got q=%0d r=%0d, want q=4 r=1", quotient, remainder);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_ena;
    int lat = 0;
    dividend = 8'd123; divisor = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    ena = 1'b1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    total_cnt++;
    if (lat !== 11) $display("FAIL ena_latency: got %0d, want 11", lat); else pass_cnt++;
    total_cnt++;
    if ({quotient, remainder} !== {8'd11, 8'd2})
      $display("FAIL ena_result: got q=%0d r=%0d, want q=11 r=2", quotient, remainder);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int n_done = 0;
    int lat, bc;
    dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0)
      $display("FAIL async_reset_outputs: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; if (done) n_done++; end
    total_cnt++;
    if (n_done !== 0) $display("FAIL async_reset_no_done: got %0d pulses, want 0", n_done);
    else pass_cnt++;
    do_op(8'd50, 8'd6, lat, bc);
    total_cnt++;
    if ({lat, quotient, remainder} !== {32'd8, 8'd8, 8'd2})
      $display("FAIL async_reset_recover: got lat=%0d q=%0d r=%0d, want lat=8 q=8 r=2",
               lat, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int lat, bc, eq, er, a, b;
    for (int n = 0; n < 3000; n++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      do_op(W'(a), W'(b), lat, bc);
      ref_div(a, b, eq, er);
      total_cnt++;
      if ({div_by_zero, quotient, remainder} !== {(b == 0), W'(eq), W'(er)})
        $display("FAIL random_%0d/%0d: got q=%0d r=%0d dbz=%0b lat=%0d, want q=%0d r=%0d dbz=%0b",
                 a, b, quotient, remainder, div_by_zero, lat, eq, er, (b == 0));
      else pass_cnt++;
      if (b != 0) begin
        total_cnt++;
        if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b)
          $display("FAIL random_invariant_%0d/%0d: got q=%0d r=%0d, want q*d+r=%0d with r<%0d",
                   a, b, quotient, remainder, a, b);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_by_zero();
    test_hold_start();
    test_back_to_back();
    test_ena();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
